// File: rtl/instr_load_if.sv
// Record channel between the boot host and the instruction loader.
// The host owns the record fields and valid; the loader drives ready back.
interface instr_load_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [12:0] in_imm;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Encodes symbolic instruction records into RV32I words, writes them sequentially
// into instruction memory and holds the core in reset until an END record arrives.
module instr_mem_loader #(
  parameter int          IMEM_WORDS = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          CNT_W      = $clog2(IMEM_WORDS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_load_if.slave      rec,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic [CNT_W-1:0] word_count,
  output logic             err,
  output logic             load_done,
  output logic             core_rst_n
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  localparam logic [2:0] OP_END = 3'd7;

  state_t      state;
  logic [31:0] enc_word;
  logic        rec_legal;
  logic        mem_full;
  logic [12:0] imm;

  assign imm          = rec.in_imm;
  assign rec.in_ready = (state == IDLE);
  assign mem_full     = (word_count >= CNT_W'(IMEM_WORDS));

  always_comb begin
    enc_word  = 32'd0;
    rec_legal = 1'b1;
    case (rec.in_op)
      3'd0: enc_word = {7'b0000000, rec.in_rs2, rec.in_rs1, 3'b000, rec.in_rd, 7'b0110011};
      3'd1: enc_word = {7'b0100000, rec.in_rs2, rec.in_rs1, 3'b000, rec.in_rd, 7'b0110011};
      3'd2: enc_word = {7'b0000000, rec.in_rs2, rec.in_rs1, 3'b111, rec.in_rd, 7'b0110011};
      3'd3: enc_word = {7'b0000000, rec.in_rs2, rec.in_rs1, 3'b110, rec.in_rd, 7'b0110011};
      3'd4: begin
        // 12-bit immediate must be a proper sign extension of the 13-bit field
        rec_legal = (imm[12] == imm[11]);
        enc_word  = {imm[11:0], rec.in_rs1, 3'b010, rec.in_rd, 7'b0000011};
      end
      3'd5: begin
        rec_legal = (imm[12] == imm[11]);
        enc_word  = {imm[11:5], rec.in_rs2, rec.in_rs1, 3'b010, imm[4:0], 7'b0100011};
      end
      3'd6: begin
        rec_legal = ~imm[0];
        enc_word  = {imm[12], imm[10:5], rec.in_rs2, rec.in_rs1, 3'b000,
                     imm[4:1], imm[11], 7'b1100011};
      end
      default: begin
        enc_word  = 32'd0;
        rec_legal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'd0;
      word_count <= '0;
      err        <= 1'b0;
      load_done  <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rec.in_valid) begin
            if (rec.in_op == OP_END) begin
              state      <= DONE;
              load_done  <= 1'b1;
              core_rst_n <= 1'b1;
            end else if (rec_legal && !mem_full) begin
              imem_wdata <= enc_word;
              imem_addr  <= BASE_ADDR + (32'(word_count) << 2);
              imem_we    <= 1'b1;
              state      <= WRITE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          // Count only once the strobe has been presented for its full cycle
          imem_we    <= 1'b0;
          word_count <= word_count + 1'b1;
          state      <= IDLE;
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a 64-word loader for the main scenarios
// and a 4-word loader for the memory-full case.
module tb_instr_mem_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid_a = 1'b0;
  logic        valid_b = 1'b0;
  logic [2:0]  op  = 3'd0;
  logic [4:0]  rd  = 5'd0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic [12:0] imm = 13'd0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  instr_load_if if_a ();
  instr_load_if if_b ();

  assign if_a.in_valid = valid_a;
  assign if_a.in_op    = op;
  assign if_a.in_rd    = rd;
  assign if_a.in_rs1   = rs1;
  assign if_a.in_rs2   = rs2;
  assign if_a.in_imm   = imm;
  assign if_b.in_valid = valid_b;
  assign if_b.in_op    = op;
  assign if_b.in_rd    = rd;
  assign if_b.in_rs1   = rs1;
  assign if_b.in_rs2   = rs2;
  assign if_b.in_imm   = imm;

  logic        we_a, err_a, done_a, crst_a;
  logic [31:0] addr_a, wdata_a;
  logic [6:0]  cnt_a;
  logic        we_b, err_b, done_b, crst_b;
  logic [31:0] addr_b, wdata_b;
  logic [2:0]  cnt_b;

  instr_mem_loader dut_a (
    .clk(clk), .rst_n(rst_n), .rec(if_a.slave),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
    .word_count(cnt_a), .err(err_a), .load_done(done_a), .core_rst_n(crst_a)
  );

  instr_mem_loader #(.IMEM_WORDS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .rec(if_b.slave),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
    .word_count(cnt_b), .err(err_b), .load_done(done_b), .core_rst_n(crst_b)
  );

  // Presents one record for a single edge; returns 1 time unit after that edge.
  task automatic send(input bit sel, input logic [2:0] o, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [12:0] im);
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total_cnt++; if ({if_a.in_ready, we_a, err_a, done_a, crst_a} !== 5'b10000) $display("FAIL reset_ctrl got %b want 10000", {if_a.in_ready, we_a, err_a, done_a, crst_a}); else pass_cnt++;
    total_cnt++; if (addr_a !== 32'h0) $display("FAIL reset_addr got %h want 00000000", addr_a); else pass_cnt++;
    total_cnt++; if (wdata_a !== 32'h0) $display("FAIL reset_wdata got %h want 00000000", wdata_a); else pass_cnt++;
    total_cnt++; if (cnt_a !== 7'd0) $display("FAIL reset_count got %0d want 0", cnt_a); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_rtype();
    send(1'b0, 3'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    $display("ADD  addr=%h wdata=%h we=%b", addr_a, wdata_a, we_a);
    total_cnt++; if (we_a !== 1'b1 || if_a.in_ready !== 1'b0) $display("FAIL add_we got we=%b ready=%b want we=1 ready=0", we_a, if_a.in_ready); else pass_cnt++;
    total_cnt++; if (addr_a !== 32'h0) $display("FAIL add_addr got %h want 00000000", addr_a); else pass_cnt++;
    total_cnt++; if (wdata_a !== 32'h002081B3) $display("FAIL add_wdata got %h want 002081B3", wdata_a); else pass_cnt++;
    next_cycle();
    total_cnt++; if (we_a !== 1'b0 || cnt_a !== 7'd1) $display("FAIL add_after got we=%b cnt=%0d want we=0 cnt=1", we_a, cnt_a); else pass_cnt++;
    send(1'b0, 3'd1, 5'd5, 5'd6, 5'd7, 13'd0);
    $display("SUB  addr=%h wdata=%h we=%b", addr_a, wdata_a, we_a);
    total_cnt++; if (we_a !== 1'b1 || addr_a !== 32'h4) $display("FAIL sub_addr got we=%b addr=%h want we=1 addr=00000004", we_a, addr_a); else pass_cnt++;
    total_cnt++; if (wdata_a !== 32'h407302B3) $display("FAIL sub_wdata got %h want 407302B3", wdata_a); else pass_cnt++;
    next_cycle();
    total_cnt++; if (cnt_a !== 7'd2) $display("FAIL rtype_count got %0d want 2", cnt_a); else pass_cnt++;
  endtask

  task automatic test_memops();
    send(1'b0, 3'd4, 5'd2, 5'd0, 5'd9, 13'd8);
    $display("LW   addr=%h wdata=%h", addr_a, wdata_a);
    total_cnt++; if (wdata_a !== 32'h00802103 || addr_a !== 32'h8) $display("FAIL lw_word got addr=%h wdata=%h want 00000008 00802103", addr_a, wdata_a); else pass_cnt++;
    next_cycle();
    send(1'b0, 3'd5, 5'd17, 5'd0, 5'd2, 13'd12);
    $display("SW   addr=%h wdata=%h", addr_a, wdata_a);
    total_cnt++; if (wdata_a !== 32'h00202623 || addr_a !== 32'hC) $display("FAIL sw_word got addr=%h wdata=%h want 0000000c 00202623", addr_a, wdata_a); else pass_cnt++;
    next_cycle();
    send(1'b0, 3'd6, 5'd0, 5'd1, 5'd2, 13'h1FF8);
    $display("BEQ  addr=%h wdata=%h", addr_a, wdata_a);
    total_cnt++; if (wdata_a !== 32'hFE208CE3 || addr_a !== 32'h10) $display("FAIL beq_word got addr=%h wdata=%h want 00000010 fe208ce3", addr_a, wdata_a); else pass_cnt++;
    next_cycle();
    total_cnt++; if (cnt_a !== 7'd5 || err_a !== 1'b0) $display("FAIL memops_count got cnt=%0d err=%b want 5 0", cnt_a, err_a); else pass_cnt++;
  endtask

  task automatic test_illegal();
    send(1'b0, 3'd6, 5'd0, 5'd1, 5'd2, 13'd3);
    $display("BEQ imm=3 we=%b err=%b cnt=%0d", we_a, err_a, cnt_a);
    total_cnt++; if ({we_a, err_a, if_a.in_ready} !== 3'b011) $display("FAIL beq_odd got we/err/ready=%b want 011", {we_a, err_a, if_a.in_ready}); else pass_cnt++;
    total_cnt++; if (cnt_a !== 7'd5) $display("FAIL beq_odd_count got %0d want 5", cnt_a); else pass_cnt++;
    send(1'b0, 3'd4, 5'd2, 5'd0, 5'd0, 13'h0800);
    $display("LW imm=0800 we=%b err=%b cnt=%0d", we_a, err_a, cnt_a);
    total_cnt++; if ({we_a, err_a, if_a.in_ready} !== 3'b011 || cnt_a !== 7'd5) $display("FAIL lw_range got we/err/ready=%b cnt=%0d want 011 5", {we_a, err_a, if_a.in_ready}, cnt_a); else pass_cnt++;
    send(1'b0, 3'd2, 5'd1, 5'd1, 5'd1, 13'd0);
    $display("AND  addr=%h wdata=%h we=%b", addr_a, wdata_a, we_a);
    total_cnt++; if (we_a !== 1'b1 || wdata_a !== 32'h0010F0B3 || addr_a !== 32'h14) $display("FAIL and_word got we=%b addr=%h wdata=%h want 1 00000014 0010f0b3", we_a, addr_a, wdata_a); else pass_cnt++;
    next_cycle();
    total_cnt++; if (cnt_a !== 7'd6 || err_a !== 1'b1) $display("FAIL illegal_sticky got cnt=%0d err=%b want 6 1", cnt_a, err_a); else pass_cnt++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 13'd0);
      $display("FULL write %0d addr=%h we=%b", i, addr_b, we_b);
      total_cnt++; if (we_b !== 1'b1 || addr_b !== 32'(i * 4)) $display("FAIL full_write%0d got we=%b addr=%h want 1 %h", i, we_b, addr_b, 32'(i * 4)); else pass_cnt++;
      next_cycle();
    end
    send(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    $display("FULL 5th we=%b err=%b cnt=%0d", we_b, err_b, cnt_b);
    total_cnt++; if (we_b !== 1'b0 || err_b !== 1'b1 || cnt_b !== 3'd4) $display("FAIL full_drop got we=%b err=%b cnt=%0d want 0 1 4", we_b, err_b, cnt_b); else pass_cnt++;
    next_cycle();
    total_cnt++; if (we_b !== 1'b0 || cnt_b !== 3'd4) $display("FAIL full_hold got we=%b cnt=%0d want 0 4", we_b, cnt_b); else pass_cnt++;
  endtask

  task automatic test_reset_mid_write();
    send(1'b0, 3'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    total_cnt++; if (we_a !== 1'b1) $display("FAIL midrst_pre got we=%b want 1", we_a); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    $display("MIDRST we=%b cnt=%0d crst=%b ready=%b", we_a, cnt_a, crst_a, if_a.in_ready);
    total_cnt++; if ({we_a, crst_a, if_a.in_ready, err_a} !== 4'b0010) $display("FAIL midrst_ctrl got we/crst/ready/err=%b want 0010", {we_a, crst_a, if_a.in_ready, err_a}); else pass_cnt++;
    total_cnt++; if (cnt_a !== 7'd0) $display("FAIL midrst_count got %0d want 0", cnt_a); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    next_cycle();
    total_cnt++; if (cnt_a !== 7'd0 || we_a !== 1'b0) $display("FAIL midrst_after got cnt=%0d we=%b want 0 0", cnt_a, we_a); else pass_cnt++;
  endtask

  task automatic test_end();
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 3'd3, 5'd4, 5'd5, 5'd6, 13'd0);
      next_cycle();
    end
    total_cnt++; if (cnt_a !== 7'd3 || done_a !== 1'b0 || crst_a !== 1'b0) $display("FAIL end_pre got cnt=%0d done=%b crst=%b want 3 0 0", cnt_a, done_a, crst_a); else pass_cnt++;
    send(1'b0, 3'd7, 5'd0, 5'd0, 5'd0, 13'd0);
    $display("END  done=%b crst=%b ready=%b", done_a, crst_a, if_a.in_ready);
    total_cnt++; if ({done_a, crst_a, if_a.in_ready, we_a} !== 4'b1100) $display("FAIL end_state got done/crst/ready/we=%b want 1100", {done_a, crst_a, if_a.in_ready, we_a}); else pass_cnt++;
    op = 3'd0; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; imm = 13'd0;
    valid_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      total_cnt++; if (we_a !== 1'b0 || cnt_a !== 7'd3 || done_a !== 1'b1) $display("FAIL end_ignore%0d got we=%b cnt=%0d done=%b want 0 3 1", i, we_a, cnt_a, done_a); else pass_cnt++;
    end
    valid_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_memops();
    test_illegal();
    test_full();
    test_reset_mid_write();
    test_end();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
